grid_renderer: RTL and testbench

- Parametrised successor to the fixed 4x4 tile-grid pixel generator: draws a ROWS x COLS grid of solid-colour cells, separated by gap lines, inside a border, for the VGA pixel path.
- Sits between the VGA sync counter (x, y, video_on, frame_tick) and the RGB output pins.
- Beyond the previous generation it adds frame-synchronous cell-colour buffering, an error-flash state machine, a blinking cursor outline and a registered 2-stage pipeline.

---
 rtl/grid_renderer_if.sv | 14 +
 rtl/grid_renderer.sv | 204 ++++++++++++++++++++
 tb/tb_grid_renderer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_renderer_if.sv
// Pixel-path bundle between the VGA sync counter and the grid renderer:
// scan position and qualifiers in, pixel colour out.
interface grid_renderer_if #(
    parameter int COLOR_W = 12
);
    logic [9:0]         x;
    logic [9:0]         y;
    logic               video_on;
    logic               frame_tick;
    logic [COLOR_W-1:0] rgb;

    modport master (output x, y, video_on, frame_tick, input rgb);
    modport slave  (input x, y, video_on, frame_tick, output rgb);
endinterface

// File: rtl/grid_renderer.sv
// ROWS x COLS grid of solid cells with gap lines and border, frame-synchronous
// colour shadowing, error-flash gaps, blinking cursor outline; 2-cycle pipeline.
//
// state        | meaning
// ST_IDLE      | no error flash, gaps drawn in GAP_COLOR
// ST_FLASH_ON  | error flash lit phase, gaps drawn in ERR_COLOR
// ST_FLASH_OFF | error flash dark phase, gaps drawn in GAP_COLOR
module grid_renderer #(
    parameter int                 ROWS         = 4,
    parameter int                 COLS         = 4,
    parameter int                 CELL_W       = 100,
    parameter int                 GAP_W        = 4,
    parameter int                 ORIGIN_X     = 110,
    parameter int                 ORIGIN_Y     = 30,
    parameter int                 COLOR_W      = 12,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = 12'h7FF,
    parameter logic [COLOR_W-1:0] GAP_COLOR    = 12'h7FF,
    parameter logic [COLOR_W-1:0] ERR_COLOR    = 12'hFFF,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = 12'hFF0,
    parameter int                 OUTLINE_W    = 3,
    parameter int                 FLASH_FRAMES = 30,
    parameter int                 BLINK_FRAMES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    grid_renderer_if.slave                pix,
    input  logic [ROWS*COLS*COLOR_W-1:0]  cells,
    input  logic                          cursor_en,
    input  logic [2:0]                    cursor_row,
    input  logic [2:0]                    cursor_col,
    input  logic                          error
);
    localparam int P        = CELL_W + GAP_W;
    localparam int GRID_W   = COLS * CELL_W + (COLS + 1) * GAP_W;
    localparam int GRID_H   = ROWS * CELL_W + (ROWS + 1) * GAP_W;
    localparam int FLASH_CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int BLINK_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {REG_BORDER, REG_GAP, REG_CELL} region_t;
    typedef enum logic [1:0] {ST_IDLE, ST_FLASH_ON, ST_FLASH_OFF} state_t;

    state_t                       state, state_nxt;
    logic [FLASH_CW-1:0]          flash_cnt, flash_cnt_nxt;
    logic [BLINK_CW-1:0]          blink_cnt;
    logic                         blink_vis;

    logic [ROWS*COLS*COLOR_W-1:0] sh_cells;
    logic                         sh_cur_en;
    logic [2:0]                   sh_cur_row;
    logic [2:0]                   sh_cur_col;

    int                           xi, yi;
    logic [COLS-1:0]              col_hit, col_edge;
    logic [ROWS-1:0]              row_hit, row_edge;
    logic                         in_x, in_y;
    logic [2:0]                   col_idx, row_idx;
    region_t                      region_d;
    logic                         outline_d;

    region_t                      s1_region;
    logic [2:0]                   s1_row, s1_col;
    logic                         s1_outline, s1_vid;
    logic [COLOR_W-1:0]           cell_color, color_d, s2_color;

    assign xi = {22'b0, pix.x};
    assign yi = {22'b0, pix.y};

    // Each cell span is a pair of constant comparators; no division needed.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int LO = ORIGIN_X + c * P + GAP_W;
        assign col_hit[c]  = (xi >= LO) && (xi < LO + CELL_W);
        assign col_edge[c] = (xi < LO + OUTLINE_W) || (xi >= LO + CELL_W - OUTLINE_W);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int LO = ORIGIN_Y + r * P + GAP_W;
        assign row_hit[r]  = (yi >= LO) && (yi < LO + CELL_W);
        assign row_edge[r] = (yi < LO + OUTLINE_W) || (yi >= LO + CELL_W - OUTLINE_W);
    end

    assign in_x = (xi >= ORIGIN_X) && (xi < ORIGIN_X + GRID_W);
    assign in_y = (yi >= ORIGIN_Y) && (yi < ORIGIN_Y + GRID_H);

    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int c = 0; c < COLS; c++)
            if (col_hit[c]) col_idx = 3'(c);
        for (int r = 0; r < ROWS; r++)
            if (row_hit[r]) row_idx = 3'(r);
    end

    always_comb begin
        region_d = REG_GAP;
        if (!(in_x && in_y))
            region_d = REG_BORDER;
        else if ((|col_hit) && (|row_hit))
            region_d = REG_CELL;
    end

    // An out-of-range cursor index can never equal a decoded row/col index.
    assign outline_d = (region_d == REG_CELL)
                     && ((|(col_hit & col_edge)) || (|(row_hit & row_edge)))
                     && sh_cur_en && blink_vis
                     && (row_idx == sh_cur_row) && (col_idx == sh_cur_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_cells   <= '0;
            sh_cur_en  <= 1'b0;
            sh_cur_row <= '0;
            sh_cur_col <= '0;
        end else if (pix.frame_tick) begin
            sh_cells   <= cells;
            sh_cur_en  <= cursor_en;
            sh_cur_row <= cursor_row;
            sh_cur_col <= cursor_col;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (pix.frame_tick) begin
            if (blink_cnt == BLINK_CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BLINK_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            flash_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flash_cnt <= flash_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flash_cnt_nxt = flash_cnt;
        if (pix.frame_tick) begin
            if (state == ST_IDLE) begin
                if (error) begin
                    state_nxt     = ST_FLASH_ON;
                    flash_cnt_nxt = '0;
                end
            end else if (!error) begin
                state_nxt     = ST_IDLE;
                flash_cnt_nxt = '0;
            end else if (flash_cnt == FLASH_CW'(FLASH_FRAMES - 1)) begin
                state_nxt     = (state == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
                flash_cnt_nxt = '0;
            end else begin
                flash_cnt_nxt = flash_cnt + FLASH_CW'(1);
            end
        end
    end

    always_comb begin
        cell_color = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (s1_row == 3'(r) && s1_col == 3'(c))
                    cell_color = sh_cells[(r * COLS + c) * COLOR_W +: COLOR_W];
    end

    always_comb begin
        case (s1_region)
            REG_BORDER: color_d = BORDER_COLOR;
            REG_GAP:    color_d = (state == ST_FLASH_ON) ? ERR_COLOR : GAP_COLOR;
            default:    color_d = s1_outline ? CURSOR_COLOR : cell_color;
        endcase
        if (!s1_vid)
            color_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_region  <= REG_BORDER;
            s1_row     <= '0;
            s1_col     <= '0;
            s1_outline <= 1'b0;
            s1_vid     <= 1'b0;
            s2_color   <= '0;
        end else begin
            s1_region  <= region_d;
            s1_row     <= row_idx;
            s1_col     <= col_idx;
            s1_outline <= outline_d;
            s1_vid     <= pix.video_on;
            s2_color   <= color_d;
        end
    end

    assign pix.rgb = s2_color;

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: directed scenarios plus randomized
// cells/cursor/error/pixels against an arithmetic reference model.
module tb_grid_renderer;
    localparam int ROWS = 4, COLS = 4, CELL = 100, GAP = 4, OX = 110, OY = 30;
    localparam int P = CELL + GAP;
    localparam int GW = COLS * CELL + (COLS + 1) * GAP;
    localparam int GH = ROWS * CELL + (ROWS + 1) * GAP;
    localparam int OW = 3, FLASH = 30, BLINK = 16;

    logic clk = 1'b0;
    logic reset;
    logic [ROWS*COLS*12-1:0] cells;
    logic cursor_en, error;
    logic [2:0] cursor_row, cursor_col;

    grid_renderer_if #(.COLOR_W(12)) pix();

    grid_renderer dut (
        .clk(clk), .reset(reset), .pix(pix), .cells(cells),
        .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference state, kept in frame-count terms
    logic [11:0] m_cells [ROWS*COLS];
    bit          m_en;
    int          m_row, m_col;
    bit          m_flash_active;
    int          m_since;
    int          m_ticks;

    task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ROWS * COLS; i++) m_cells[i] = 12'h000;
        m_en = 0; m_row = 0; m_col = 0;
        m_flash_active = 0; m_since = 0; m_ticks = 0;
    endfunction

    function automatic logic [11:0] model_rgb(int px, int py, bit vid);
        int lx, ly, cx, cy, ox, oy;
        bit flash_on, blink_on;
        if (!vid) return 12'h000;
        if (px < OX || px >= OX + GW || py < OY || py >= OY + GH) return 12'h7FF;
        lx = px - OX;
        ly = py - OY;
        flash_on = m_flash_active && ((m_since / FLASH) % 2 == 0);
        if (lx % P < GAP || lx >= COLS * P || ly % P < GAP || ly >= ROWS * P)
            return flash_on ? 12'hFFF : 12'h7FF;
        cx = lx / P; cy = ly / P;
        ox = lx % P - GAP; oy = ly % P - GAP;
        blink_on = ((m_ticks / BLINK) % 2 == 0);
        if (m_en && blink_on && cx == m_col && cy == m_row &&
            (ox < OW || ox >= CELL - OW || oy < OW || oy >= CELL - OW))
            return 12'hFF0;
        return m_cells[cy * COLS + cx];
    endfunction

    task automatic tick();
        pix.video_on = 1'b0;
        pix.frame_tick = 1'b1;
        @(posedge clk); #1;
        pix.frame_tick = 1'b0;
        for (int i = 0; i < ROWS * COLS; i++) m_cells[i] = cells[i*12 +: 12];
        m_en = cursor_en; m_row = int'(cursor_row); m_col = int'(cursor_col);
        if (!m_flash_active && error) begin
            m_flash_active = 1; m_since = 0;
        end else if (m_flash_active && !error) begin
            m_flash_active = 0;
        end else if (m_flash_active) begin
            m_since++;
        end
        m_ticks++;
    endtask

    task automatic pix_chk(string tag, int px, int py, bit vid, logic [11:0] exp);
        pix.x = 10'(px); pix.y = 10'(py); pix.video_on = vid;
        @(posedge clk); @(posedge clk); #1;
        chk(tag, pix.rgb, exp);
    endtask

    task automatic pix_model(string tag, int px, int py, bit vid);
        pix_chk(tag, px, py, vid, model_rgb(px, py, vid));
    endtask

    initial begin
        int px, py;
        reset = 1'b1;
        pix.x = 10'd114; pix.y = 10'd34; pix.video_on = 1'b1; pix.frame_tick = 1'b0;
        cells = '0; cursor_en = 1'b0; cursor_row = '0; cursor_col = '0; error = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", pix.rgb, 12'h000);
        reset = 1'b0;

        // step 1: geometry
        for (int i = 0; i < ROWS * COLS; i++) cells[i*12 +: 12] = 12'h123;
        cells[11:0] = 12'hF00;
        tick();
        pix_chk("cell00",      114, 34,  1, 12'hF00);
        pix_chk("gap_left",    113, 34,  1, 12'h7FF);
        pix_chk("border_left", 109, 100, 1, 12'h7FF);
        pix_chk("border_right",530, 100, 1, 12'h7FF);
        pix_chk("cell01",      218, 34,  1, 12'h123);
        pix_model("last_gap_x", 529, 100, 1);

        // step 2: shadowing
        cells[11:0] = 12'h0F0;
        pix_chk("shadow_hold", 114, 34, 1, 12'hF00);
        tick();
        pix_chk("shadow_new",  114, 34, 1, 12'h0F0);

        // step 3: error flash
        error = 1'b1;
        tick();
        pix_chk("flash_on", 112, 100, 1, 12'hFFF);
        pix_chk("flash_cell_untouched", 114, 34, 1, 12'h0F0);
        for (int i = 0; i < FLASH; i++) begin
            tick();
            if (i == FLASH - 2) pix_chk("flash_on_last", 112, 100, 1, 12'hFFF);
        end
        pix_chk("flash_off", 112, 100, 1, 12'h7FF);
        repeat (FLASH) tick();
        pix_chk("flash_on_again", 112, 100, 1, 12'hFFF);
        error = 1'b0;
        tick();
        pix_chk("flash_idle", 112, 100, 1, 12'h7FF);

        // step 4: cursor outline on cell (1,2)
        cursor_en = 1'b1; cursor_row = 3'd1; cursor_col = 3'd2;
        tick();
        pix_chk("cur_corner",   322, 138, 1, 12'hFF0);
        pix_chk("cur_inner",    324, 140, 1, 12'hFF0);
        pix_chk("cur_interior", 325, 141, 1, 12'h123);
        pix_chk("cur_far",      421, 237, 1, 12'hFF0);
        pix_chk("cur_left_gap", 321, 138, 1, 12'h7FF);
        repeat (BLINK) tick();
        pix_chk("cur_blink_off", 322, 138, 1, 12'h123);
        repeat (BLINK - 1) tick();
        pix_chk("cur_blink_on",  322, 138, 1, 12'hFF0);

        // step 5: out-of-range cursor row
        cursor_row = 3'd4;
        tick();
        pix_chk("cur_oob_a", 322, 138, 1, 12'h123);
        pix_chk("cur_oob_b", 322, 346, 1, 12'h123);
        pix_chk("cur_oob_c", 421, 445, 1, 12'h123);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < ROWS * COLS; i++) cells[i*12 +: 12] = 12'($urandom);
            cursor_en  = 1'($urandom_range(0, 3) != 0);
            cursor_row = 3'($urandom_range(0, 4));
            cursor_col = 3'($urandom_range(0, 4));
            error      = 1'($urandom_range(0, 3) != 0);
            tick();
            for (int k = 0; k < 5; k++) begin
                if (k < 2 && cursor_col < 4 && cursor_row < 4) begin
                    px = OX + int'(cursor_col) * P + GAP + $urandom_range(0, 5);
                    py = OY + int'(cursor_row) * P + GAP + $urandom_range(0, CELL - 1);
                    if (k == 1) px = px + CELL - 6;
                end else begin
                    px = $urandom_range(100, 545);
                    py = $urandom_range(20, 460);
                end
                pix_model("rand_pix", px, py, 1'($urandom_range(0, 7) != 0));
            end
        end

        // step 6: video_on and reset during flash
        pix_chk("video_off", 114, 34, 0, 12'h000);
        error = 1'b0;
        tick();
        error = 1'b1;
        tick();
        pix_chk("pre_reset_flash", 112, 100, 1, 12'hFFF);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_next_edge", pix.rgb, 12'h000);
        @(posedge clk); #1;
        chk("reset_held", pix.rgb, 12'h000);
        reset = 1'b0;
        error = 1'b0;
        model_reset();
        pix_chk("post_reset_gap",  112, 100, 1, 12'h7FF);
        pix_chk("post_reset_cell", 114, 34,  1, 12'h000);
        pix_model("post_reset_border", 50, 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
